// File: rtl/eq_cmp_checker_pkg.sv
// eq_cmp_checker_pkg: shared FSM state encoding and settle counter width
package eq_cmp_checker_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_CHECK, ST_DONE} state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/eq_cmp_checker_ref.sv
// eq_ref: combinational golden equality comparator
module eq_ref #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);
  assign eq = a == b;
endmodule

// File: rtl/eq_cmp_checker.sv
// eq_cmp_checker: sweeps all operand pairs into an equality comparator and checks eq_in
module eq_cmp_checker
  import eq_cmp_checker_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               eq_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);
  localparam logic [CNT_W-1:0] SET_M1 = CNT_W'(SETTLE == 0 ? 0 : SETTLE - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] idx;
  logic exp_eq, last, mism;
  assign idx  = {a_out, b_out};
  assign last = &idx;
  assign mism = eq_in != exp_eq;
  eq_ref #(.WIDTH(WIDTH)) u_ref (.a(a_out), .b(b_out), .eq(exp_eq));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  // next-state: one vector is DRIVE, SETTLE x WAIT, then CHECK
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = start ? ST_DRIVE : ST_IDLE;
      ST_DRIVE: state_nxt = SETTLE == 0 ? ST_CHECK : ST_WAIT;
      ST_WAIT:  state_nxt = cnt == '0 ? ST_CHECK : ST_WAIT;
      ST_CHECK: state_nxt = last ? ST_DONE : ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end
  // operands, settle counter, status flags and mismatch bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {a_out, b_out, err_count, pass, fail_valid, fail_a, fail_b} <= '0;
      {busy, done} <= '0;
      cnt <= '0;
    end else begin
      busy <= state_nxt inside {ST_DRIVE, ST_WAIT, ST_CHECK};
      done <= state_nxt == ST_DONE;
      if (state == ST_IDLE && start)
        {a_out, b_out, err_count, pass, fail_valid, fail_a, fail_b} <= '0;
      if (state == ST_DRIVE) cnt <= SET_M1;
      if (state == ST_WAIT) cnt <= cnt - 1'b1;
      if (state == ST_CHECK) begin
        if (mism) begin
          err_count <= err_count + 1'b1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a_out;
            fail_b     <= b_out;
          end
        end
        if (last) pass <= !mism && err_count == '0;
        else {a_out, b_out} <= idx + 1'b1;
      end
    end
endmodule
